// File: rtl/ssc_iq_corr_if.sv
// Register-bus and ADC sample port bundle for one correlator channel.
// The master drives addr/Wdata/strobes and samples; the channel answers with Rdata/cseen.
interface ssc_iq_corr_if #(
  parameter int ADC_W = 16
);
  logic [31:0]             addr;
  logic [31:0]             Wdata;
  logic                    write;
  logic                    read;
  logic [31:0]             Rdata;
  logic signed [ADC_W-1:0] ADC;
  logic                    pushADC;
  logic                    cseen;

  modport master (output addr, Wdata, write, read, ADC, pushADC, input Rdata, cseen);
  modport slave  (input addr, Wdata, write, read, ADC, pushADC, output Rdata, cseen);
endinterface

// File: rtl/ssc_iq_corr.sv
// Spread-spectrum I/Q correlator channel: carrier NCO + sin/cos lookup, chip NCO stepping a Galois LFSR,
// 3-stage multiply pipeline feeding I/Q integrators that dump on every PRN epoch. Accepts one sample per cycle.
module ssc_iq_corr #(
  parameter logic [15:0] BASE    = 16'h0340,
  parameter int          ADC_W   = 16,
  parameter int          PHASE_W = 32,
  parameter int          LFSR_W  = 14,
  parameter int          ACC_W   = 64
) (
  input logic           clk,
  input logic           rst,
  ssc_iq_corr_if.slave  bus
);

  localparam logic [PHASE_W-1:0] QTR = {2'b01, {(PHASE_W-2){1'b0}}};
  localparam int                 PRD_W = ADC_W + 17;

  // Quarter-wave table: 13-bit index, 16-bit magnitude, folded to a full signed wave.
  function automatic logic signed [16:0] qlut(input logic [PHASE_W-1:0] ph);
    logic [12:0]        idx;
    logic [27:0]        sq;
    logic signed [16:0] mag;
    idx = ph[PHASE_W-3 -: 13];
    if (ph[PHASE_W-2]) idx = ~idx;
    sq  = {15'd0, idx} * (28'd16384 - {15'd0, idx});
    mag = 17'(sq >> 10);
    return ph[PHASE_W-1] ? -mag : mag;
  endfunction

  logic                     en;
  logic [PHASE_W-1:0]       carr_freq, carr_phase, chip_freq, chip_phase;
  logic [LFSR_W-1:0]        prn_state, prn_poly, epoch_reg;
  logic [3:0]               hob;
  logic [31:0]              corr_cnt, cnt;
  logic signed [ACC_W-1:0]  dump_i, dump_q, acc_i, acc_q;
  logic                     st_valid, st_overrun;

  logic                     s1_vld, s1_chip, s1_epoch;
  logic signed [ADC_W-1:0]  s1_adc;
  logic [PHASE_W-1:0]       s1_phase;
  logic                     s2_vld, s2_chip, s2_epoch;
  logic signed [ADC_W-1:0]  s2_adc;
  logic signed [16:0]       s2_sin, s2_cos;
  logic                     s3_vld, s3_epoch;
  logic signed [ACC_W-1:0]  s3_pi, s3_pq;

  // Address decode
  logic [15:0] off;
  logic        hit;
  logic [3:0]  ridx;
  logic [14:0] wsel;
  assign off  = bus.addr[15:0] - BASE;
  assign ridx = off[5:2];
  assign hit  = (off[15:6] == 10'd0) && (off[1:0] == 2'd0) && (ridx != 4'hF);
  assign wsel = (bus.write && hit) ? (15'd1 << ridx) : 15'd0;

  logic clr, w1c_v, w1c_o;
  assign clr   = wsel[0]  & bus.Wdata[1];
  assign w1c_v = wsel[14] & bus.Wdata[0];
  assign w1c_o = wsel[14] & bus.Wdata[1];

  // Accept, chip NCO carry and LFSR step
  logic               accept, chip_carry, lfsr_x, step, epoch_hit;
  logic [PHASE_W-1:0] chip_sum;
  logic [LFSR_W-1:0]  hob_mask, lfsr_next;
  assign accept                 = bus.pushADC & en;
  assign {chip_carry, chip_sum} = {1'b0, chip_phase} + {1'b0, chip_freq};
  assign hob_mask               = LFSR_W'(1) << hob;
  assign lfsr_x                 = |(prn_state & hob_mask);
  assign lfsr_next              = ((prn_state & ~hob_mask) << 1) ^ (lfsr_x ? prn_poly : '0);
  assign step                   = accept & chip_carry;
  assign epoch_hit              = step && (lfsr_next == epoch_reg);

  // Products, sign-extended to the accumulator width and despread by the chip
  logic signed [PRD_W-1:0] prod_i, prod_q;
  logic signed [ACC_W-1:0] ext_i, ext_q;
  assign prod_i = PRD_W'(s2_adc) * PRD_W'(s2_sin);
  assign prod_q = PRD_W'(s2_adc) * PRD_W'(s2_cos);
  assign ext_i  = ACC_W'(prod_i);
  assign ext_q  = ACC_W'(prod_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      en <= 1'b0;
      carr_freq <= '0; carr_phase <= '0; chip_freq <= '0; chip_phase <= '0;
      prn_state <= '0; prn_poly <= '0; hob <= '0; epoch_reg <= LFSR_W'(1);
      corr_cnt <= '0; cnt <= '0; dump_i <= '0; dump_q <= '0; acc_i <= '0; acc_q <= '0;
      st_valid <= 1'b0; st_overrun <= 1'b0;
      s1_vld <= 1'b0; s1_chip <= 1'b0; s1_epoch <= 1'b0; s1_adc <= '0; s1_phase <= '0;
      s2_vld <= 1'b0; s2_chip <= 1'b0; s2_epoch <= 1'b0; s2_adc <= '0; s2_sin <= '0; s2_cos <= '0;
      s3_vld <= 1'b0; s3_epoch <= 1'b0; s3_pi <= '0; s3_pq <= '0;
    end else begin
      if (accept) begin
        carr_phase <= carr_phase + carr_freq;
        chip_phase <= chip_sum;
        if (step) prn_state <= lfsr_next;
      end
      // Bus writes come last so they override same-cycle NCO/LFSR updates.
      if (wsel[0])  en         <= bus.Wdata[0];
      if (wsel[1])  carr_freq  <= bus.Wdata[PHASE_W-1:0];
      if (wsel[2])  carr_phase <= bus.Wdata[PHASE_W-1:0];
      if (wsel[3])  chip_freq  <= bus.Wdata[PHASE_W-1:0];
      if (wsel[4])  chip_phase <= bus.Wdata[PHASE_W-1:0];
      if (wsel[5])  prn_state  <= bus.Wdata[LFSR_W-1:0];
      if (wsel[6])  prn_poly   <= bus.Wdata[LFSR_W-1:0];
      if (wsel[7])  hob        <= bus.Wdata[3:0];
      if (wsel[8])  epoch_reg  <= bus.Wdata[LFSR_W-1:0];

      s1_vld   <= accept & ~clr;
      s1_adc   <= bus.ADC;
      s1_phase <= carr_phase;
      s1_chip  <= lfsr_x;
      s1_epoch <= epoch_hit;

      s2_vld   <= s1_vld & ~clr;
      s2_adc   <= s1_adc;
      s2_sin   <= qlut(s1_phase);
      s2_cos   <= qlut(s1_phase + QTR);
      s2_chip  <= s1_chip;
      s2_epoch <= s1_epoch;

      s3_vld   <= s2_vld & ~clr;
      s3_pi    <= s2_chip ? -ext_i : ext_i;
      s3_pq    <= s2_chip ? -ext_q : ext_q;
      s3_epoch <= s2_epoch;

      if (clr) begin
        acc_i <= '0; acc_q <= '0; cnt <= '0;
      end else if (s3_vld) begin
        if (s3_epoch) begin
          dump_i   <= acc_i;
          dump_q   <= acc_q;
          corr_cnt <= cnt;
          acc_i    <= s3_pi;
          acc_q    <= s3_pq;
          cnt      <= 32'd1;
        end else begin
          acc_i <= acc_i + s3_pi;
          acc_q <= acc_q + s3_pq;
          cnt   <= cnt + 32'd1;
        end
      end

      // A dump outranks a same-cycle write-1-to-clear of STATUS.
      if (!clr && s3_vld && s3_epoch) begin
        st_valid   <= 1'b1;
        st_overrun <= (st_overrun & ~w1c_o) | st_valid;
      end else begin
        if (w1c_v) st_valid   <= 1'b0;
        if (w1c_o) st_overrun <= 1'b0;
      end
    end
  end

  logic signed [63:0] di64, dq64;
  logic [31:0]        rd_val;
  assign di64 = 64'(dump_i);
  assign dq64 = 64'(dump_q);

  always_comb begin
    rd_val = '0;
    case (ridx)
      4'h0: rd_val = {31'd0, en};
      4'h1: rd_val = 32'(carr_freq);
      4'h2: rd_val = 32'(carr_phase);
      4'h3: rd_val = 32'(chip_freq);
      4'h4: rd_val = 32'(chip_phase);
      4'h5: rd_val = 32'(prn_state);
      4'h6: rd_val = 32'(prn_poly);
      4'h7: rd_val = {28'd0, hob};
      4'h8: rd_val = 32'(epoch_reg);
      4'h9: rd_val = corr_cnt;
      4'hA: rd_val = di64[31:0];
      4'hB: rd_val = di64[63:32];
      4'hC: rd_val = dq64[31:0];
      4'hD: rd_val = dq64[63:32];
      4'hE: rd_val = {30'd0, st_overrun, st_valid};
      default: rd_val = '0;
    endcase
  end

  assign bus.Rdata = (bus.read && hit) ? rd_val : 32'd0;
  assign bus.cseen = st_valid;

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:16], bus.Wdata};

endmodule

// File: tb/tb_ssc_iq_corr.sv
// Bench for ssc_iq_corr: register table, directed latency/collision/reset sequences,
// then randomized segments checked against an arithmetic reference model.
module tb_ssc_iq_corr;
  localparam logic [15:0] BASE = 16'h0340;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssc_iq_corr_if #(.ADC_W(16)) bus();
  ssc_iq_corr dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  off;
    bit          do_wr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  // Reference model state
  int unsigned m_cf, m_cp, m_hf, m_hp, m_cnt, m_dcnt;
  logic [13:0] m_st, m_poly, m_ep;
  int          m_hob;
  longint      m_ai, m_aq, m_di, m_dq;
  bit          m_v, m_o, m_en;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.addr = {16'h0, BASE + {8'h0, off}}; bus.Wdata = d; bus.write = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    bus.addr = {16'h0, BASE + {8'h0, off}}; bus.read = 1'b1;
    #1 d = bus.Rdata;
    bus.read = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    chk(name, d, exp);
  endtask

  task automatic push(input logic signed [15:0] a);
    bus.ADC = a; bus.pushADC = 1'b1;
    @(posedge clk); #1;
    bus.pushADC = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full-wave value from a 32-bit phase: quadrant folding of a parabolic quarter wave.
  function automatic longint qsin(input int unsigned ph);
    longint q, t, m;
    q = longint'(ph) / 64'h4000_0000;
    t = (longint'(ph) % 64'h4000_0000) / 64'h2_0000;
    if (q % 2 == 1) t = 8191 - t;
    m = t * (16384 - t) / 1024;
    return (q >= 2) ? -m : m;
  endfunction

  task automatic model_reset();
    m_cf = 0; m_cp = 0; m_hf = 0; m_hp = 0; m_cnt = 0; m_dcnt = 0;
    m_st = 0; m_poly = 0; m_ep = 14'd1; m_hob = 0;
    m_ai = 0; m_aq = 0; m_di = 0; m_dq = 0; m_v = 0; m_o = 0; m_en = 0;
  endtask

  task automatic model_accept(input logic signed [15:0] a);
    longint      s, c, pi, pq, sum;
    bit          chip, ep, x;
    logic [13:0] st;
    s = qsin(m_cp);
    c = qsin(m_cp + 32'h4000_0000);
    chip = m_st[m_hob];
    ep = 0;
    sum = longint'(m_hp) + longint'(m_hf);
    if (sum >= 64'h1_0000_0000) begin
      st = m_st; x = st[m_hob]; st[m_hob] = 1'b0; st = st << 1;
      if (x) st = st ^ m_poly;
      m_st = st;
      ep = (st == m_ep);
    end
    m_hp = int'(sum);
    m_cp = m_cp + m_cf;
    pi = longint'(a) * s;
    pq = longint'(a) * c;
    if (chip) begin pi = -pi; pq = -pq; end
    if (ep) begin
      m_di = m_ai; m_dq = m_aq; m_dcnt = m_cnt;
      m_o = m_o | m_v; m_v = 1;
      m_ai = pi; m_aq = pq; m_cnt = 1;
    end else begin
      m_ai += pi; m_aq += pq; m_cnt++;
    end
  endtask

  task automatic mwr(input logic [7:0] off, input logic [31:0] d);
    wr(off, d);
    case (off)
      8'h00: begin m_en = d[0]; if (d[1]) begin m_ai = 0; m_aq = 0; m_cnt = 0; end end
      8'h04: m_cf = d;
      8'h08: m_cp = d;
      8'h0C: m_hf = d;
      8'h10: m_hp = d;
      8'h14: m_st = d[13:0];
      8'h18: m_poly = d[13:0];
      8'h1C: m_hob = int'(d[3:0]);
      8'h20: m_ep = d[13:0];
      8'h38: begin if (d[0]) m_v = 0; if (d[1]) m_o = 0; end
      default: ;
    endcase
  endtask

  task automatic mpush(input logic signed [15:0] a);
    push(a);
    if (m_en) model_accept(a);
  endtask

  initial begin
    logic [31:0]        d;
    logic [63:0]        qexp;
    logic signed [15:0] a;
    int                 n;

    tbl[0]  = '{8'h00, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{8'h20, 1'b0, 32'h0,         32'h1};
    tbl[2]  = '{8'h38, 1'b0, 32'h0,         32'h0};
    tbl[3]  = '{8'h24, 1'b0, 32'h0,         32'h0};
    tbl[4]  = '{8'h04, 1'b1, 32'h1234_5678, 32'h1234_5678};
    tbl[5]  = '{8'h1C, 1'b1, 32'hFF,        32'hF};
    tbl[6]  = '{8'h14, 1'b1, 32'hFFFF_FFFF, 32'h3FFF};
    tbl[7]  = '{8'h24, 1'b1, 32'hABCD,      32'h0};
    tbl[8]  = '{8'h00, 1'b1, 32'h3,         32'h1};
    tbl[9]  = '{8'h00, 1'b1, 32'h0,         32'h0};
    tbl[10] = '{8'h3C, 1'b0, 32'h0,         32'h0};
    tbl[11] = '{8'h18, 1'b1, 32'h5,         32'h5};

    bus.addr = '0; bus.Wdata = '0; bus.write = 0; bus.read = 0; bus.ADC = '0; bus.pushADC = 0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("reset_cseen", bus.cseen, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].do_wr) wr(tbl[i].off, tbl[i].wdat);
      rdchk($sformatf("tbl%0d", i), tbl[i].off, tbl[i].exp);
    end
    @(negedge clk);
    bus.addr = {16'h0, BASE + 16'h20}; bus.read = 1'b0;
    #1 chk("rdata_idle", bus.Rdata, 32'h0);

    // LFSR step
    wr(8'h1C, 3); wr(8'h18, 3); wr(8'h14, 8); wr(8'h0C, 32'h8000_0000); wr(8'h10, 0); wr(8'h00, 1);
    push(5); push(5);
    rdchk("lfsr_step", 8'h14, 32'h3);

    // DC carrier, 10 samples then epoch
    wr(8'h04, 0); wr(8'h08, 0); wr(8'h0C, 1); wr(8'h10, 32'hFFFF_FFF5);
    wr(8'h14, 1); wr(8'h18, 3); wr(8'h20, 2); wr(8'h00, 3);
    bus.ADC = 16'sd100; bus.pushADC = 1'b1;
    idle(11);
    bus.pushADC = 1'b0;
    idle(4);
    qexp = 64'(1000 * qsin(32'h4000_0000));
    rdchk("dc_cnt", 8'h24, 32'd10);
    rdchk("dc_i_lo", 8'h28, 32'h0);
    rdchk("dc_i_hi", 8'h2C, 32'h0);
    rdchk("dc_q_lo", 8'h30, qexp[31:0]);
    rdchk("dc_q_hi", 8'h34, qexp[63:32]);
    rdchk("dc_status", 8'h38, 32'h1);
    chk("dc_cseen", bus.cseen, 1'b1);

    // Dump latency of a single epoch sample
    wr(8'h38, 3); wr(8'h10, 32'hFFFF_FFFF); wr(8'h20, 4);
    bus.ADC = 16'sd100; bus.pushADC = 1'b1;
    @(posedge clk); #1 bus.pushADC = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat_cseen_%0d", k), bus.cseen, (k == 4));
      if (k < 4) @(posedge clk);
    end
    qexp = 64'(100 * qsin(32'h4000_0000));
    rdchk("lat_cnt", 8'h24, 32'd1);
    rdchk("lat_q_lo", 8'h30, qexp[31:0]);

    // Overrun
    wr(8'h10, 32'hFFFF_FFFF); wr(8'h20, 8);
    push(100); idle(4);
    rdchk("ovr_status", 8'h38, 32'h3);
    wr(8'h38, 3);
    rdchk("ovr_clear", 8'h38, 32'h0);
    chk("ovr_cseen", bus.cseen, 1'b0);

    // STATUS clear colliding with a dump
    wr(8'h10, 32'hFFFF_FFFF); wr(8'h20, 3);
    push(100); idle(2); wr(8'h38, 3);
    rdchk("coll_status", 8'h38, 32'h1);

    // CARR_PHASE write in an accept cycle
    wr(8'h04, 32'h1000);
    bus.ADC = 16'sd7; bus.pushADC = 1'b1;
    bus.addr = {16'h0, BASE + 16'h08}; bus.Wdata = 32'hDEAD_BEEF; bus.write = 1'b1;
    @(posedge clk); #1 bus.pushADC = 1'b0; bus.write = 1'b0;
    rdchk("coll_phase", 8'h08, 32'hDEAD_BEEF);
    push(7);
    rdchk("phase_adv", 8'h08, 32'hDEAD_CEEF);

    // Reset with an epoch sample in flight
    wr(8'h38, 3); wr(8'h10, 32'hFFFF_FFFD); wr(8'h20, 6);
    bus.ADC = 16'sd50; bus.pushADC = 1'b1;
    idle(3);
    bus.pushADC = 1'b0; rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    chk("rst_cseen", bus.cseen, 1'b0);
    rdchk("rst_status", 8'h38, 32'h0);
    rdchk("rst_epoch", 8'h20, 32'h1);
    rdchk("rst_cnt", 8'h24, 32'h0);
    rdchk("rst_cfreq", 8'h04, 32'h0);
    rdchk("rst_state", 8'h14, 32'h0);
    rdchk("rst_ctrl", 8'h00, 32'h0);
    rdchk("rst_q_lo", 8'h30, 32'h0);

    // Randomized segments against the model
    model_reset();
    mwr(8'h1C, 3);
    mwr(8'h18, $urandom_range(0, 7) * 2 + 1);
    mwr(8'h14, $urandom_range(1, 15));
    mwr(8'h00, 1);
    for (int seg = 0; seg < 16; seg++) begin
      mwr(8'h04, $urandom); mwr(8'h08, $urandom); mwr(8'h0C, $urandom);
      mwr(8'h20, $urandom_range(1, 15));
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        a = 16'($urandom);
        mpush(a);
      end
      idle(5);
      rdchk($sformatf("rnd%0d_cnt", seg), 8'h24, m_dcnt);
      rdchk($sformatf("rnd%0d_i_lo", seg), 8'h28, m_di[31:0]);
      rdchk($sformatf("rnd%0d_i_hi", seg), 8'h2C, m_di[63:32]);
      rdchk($sformatf("rnd%0d_q_lo", seg), 8'h30, m_dq[31:0]);
      rdchk($sformatf("rnd%0d_q_hi", seg), 8'h34, m_dq[63:32]);
      rdchk($sformatf("rnd%0d_status", seg), 8'h38, {30'd0, m_o, m_v});
      rdchk($sformatf("rnd%0d_state", seg), 8'h14, {18'd0, m_st});
      rdchk($sformatf("rnd%0d_cphase", seg), 8'h08, m_cp);
      chk($sformatf("rnd%0d_cseen", seg), bus.cseen, m_v);
      mwr(8'h38, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
